xram_ctrl: RTL and testbench
============================

XRAM_CTRL -- requirements
Module: xram_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports a_req, a_we  in  1 each  requester A (CPU) request and write flag.
REQ-004 SHALL have ports a_addr  in  15, a_wdata  in  16, a_be  in  2  A word address, write data, byte enables (bit0 = low byte).
REQ-005 SHALL have ports a_rdata  out  16, a_ack  out  1  A read data and one-cycle completion pulse.
REQ-006 SHALL have identical port set b_* (requester B, UART loader).
REQ-007 SHALL have ports xlal, xlah, xbh  out  1 each  low/high address-latch enables and byte select.
REQ-008 SHALL have ports xoeb, xweb  out  1 each  SRAM output enable and write strobe, both active-low.
REQ-009 SHALL have ports uio_out  out  8, uio_oe  out  8, uio_in  in  8  shared address/data bus.

Function
REQ-010 SHALL form the SRAM byte address as {latched word address[14:0], xbh}; latch-low takes addr[7:0], latch-high takes {1'b0, addr[14:8]}.
REQ-011 SHALL register every bus output (Moore outputs); idle values: xlal=xlah=xbh=0, xoeb=xweb=1, uio_oe=0x00, uio_out=0x00.
REQ-012 SHALL use states IDLE, LAL, LAH, B0S, B0P, B1S, B1P, ACK.
REQ-013 IDLE: on any req, SHALL grant round-robin (A wins a tie when B was granted last, or after reset) and capture the winner's addr/we/wdata/be.
REQ-014 LAL: uio_oe=0xFF, uio_out=addr[7:0], xlal=1, one cycle.
REQ-015 LAH: uio_oe=0xFF, uio_out={0,addr[14:8]}, xlah=1, one cycle; SHALL be skipped when the high-latch-valid flag is set and addr[14:8] equals the last latched high byte.
REQ-016 Read byte phases: BnS has xoeb=0, xbh=n, uio_oe=0x00; BnP the same; uio_in SHALL be sampled into rdata byte n at the end of BnP.
REQ-017 Write byte phases: BnS drives uio_oe=0xFF, data byte n, xbh=n, xweb=1; BnP keeps the same and sets xweb=0.
REQ-018 Writes SHALL skip the phases of a byte whose be bit is 0; a write with be=2'b00 SHALL go IDLE->ACK with no bus activity and no latch.
REQ-019 Reads SHALL ignore be and always transfer both bytes.
REQ-020 ACK: one-cycle ack to the granted port only, rdata held stable until that port's next ack; then return to IDLE.
REQ-021 Latency from grant edge to ack: 7 cycles for a full-word access, 6 with LAH skipped, 5 for a single-byte write (4 with LAH skipped).
REQ-022 Requesters SHALL hold req/addr/we/wdata/be stable until ack and drop req the cycle after ack; req still high in IDLE after ACK counts as a new request.
REQ-023 Changes on req/addr/wdata of either port outside IDLE SHALL NOT affect the transaction in flight.
REQ-024 Drive conflict SHALL never occur: uio_oe=0xFF and xoeb=0 are mutually exclusive in every cycle.

Reset
REQ-025 reset SHALL asynchronously force IDLE, idle bus values, a_ack=b_ack=0, rdata=0, round-robin pointer to "B last", and clear the high-latch-valid flag.
REQ-026 Reset mid-transaction SHALL abort without issuing ack; a partially written word is allowed.

Structure
REQ-027 Shared package xram_pkg SHALL hold the state enum, port-index constants (PORT_A=0, PORT_B=1) and the idle bus constants.
REQ-028 The round-robin grant SHALL be a sub-module xram_arb (2 requests, enable, grant, last-grant register).
REQ-029 Target size: 150-300 RTL lines.

Verification
REQ-030 A write addr=0x1234, wdata=0xBEEF, be=11 -> LAL bus 0x34, LAH bus 0x12, SRAM[0x2468]=0xEF, SRAM[0x2469]=0xBE, ack 7 cycles after grant.
REQ-031 A read of 0x1234 directly after -> LAH skipped, a_rdata=0xBEEF, ack 6 cycles after grant.
REQ-032 A and B req in the same cycle, both held -> grants in order A, B, A; each ack pulses exactly one cycle, on its own port only.
REQ-033 B write be=10 to 0x0100 with data 0x55AA -> only SRAM[0x0201]=0x55 written; xbh=0 is never strobed; be=00 -> ack 2 cycles after grant, no xweb edge.
REQ-034 reset asserted during B0P of a write -> outputs idle in the same cycle, no ack; next access to the same high byte still performs LAH.
REQ-035 All tests -> assertion that uio_oe=0xFF and xoeb=0 never coincide, and that xweb falls only when uio_oe=0xFF.

Source files
------------

// File: rtl/xram_pkg.sv
// xram_pkg: shared state encoding, port indices, request/bus record types and
// idle bus values for the external SRAM controller.
package xram_pkg;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef logic [2:0] xram_state_t;
  localparam xram_state_t ST_IDLE = 3'd0;
  localparam xram_state_t ST_LAL  = 3'd1;
  localparam xram_state_t ST_LAH  = 3'd2;
  localparam xram_state_t ST_B0S  = 3'd3;
  localparam xram_state_t ST_B0P  = 3'd4;
  localparam xram_state_t ST_B1S  = 3'd5;
  localparam xram_state_t ST_B1P  = 3'd6;
  localparam xram_state_t ST_ACK  = 3'd7;

  localparam logic       IDLE_XLAL    = 1'b0;
  localparam logic       IDLE_XLAH    = 1'b0;
  localparam logic       IDLE_XBH     = 1'b0;
  localparam logic       IDLE_XOEB    = 1'b1;
  localparam logic       IDLE_XWEB    = 1'b1;
  localparam logic [7:0] IDLE_UIO_OUT = 8'h00;
  localparam logic [7:0] IDLE_UIO_OE  = 8'h00;

  typedef struct packed {
    logic        we;
    logic [14:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } xram_req_t;

  typedef struct packed {
    logic       xlal;
    logic       xlah;
    logic       xbh;
    logic       xoeb;
    logic       xweb;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
  } xram_bus_t;

  localparam xram_bus_t BUS_IDLE = '{
    xlal: IDLE_XLAL, xlah: IDLE_XLAH, xbh: IDLE_XBH, xoeb: IDLE_XOEB,
    xweb: IDLE_XWEB, uio_out: IDLE_UIO_OUT, uio_oe: IDLE_UIO_OE
  };

  function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/xram_arb.sv
// xram_arb: two-way round-robin grant with a registered last-grant pointer.
module xram_arb
  import xram_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       last
);

  logic last_r;
  logic [1:0] gnt_s;

  // Lone requester wins; on a tie the port not served last wins
  always_comb begin
    gnt_s = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt_s = 2'b01;
        2'b10:   gnt_s = 2'b10;
        2'b11:   gnt_s = (last_r == PORT_A) ? 2'b10 : 2'b01;
        default: gnt_s = 2'b00;
      endcase
    end else begin
      gnt_s = 2'b00;
    end
  end

  // Last-grant pointer, starts as if B had been served
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_r <= PORT_B;
    end else if (gnt_s[0]) begin
      last_r <= PORT_A;
    end else if (gnt_s[1]) begin
      last_r <= PORT_B;
    end
  end

  assign gnt  = gnt_s;
  assign last = last_r;

endmodule

// File: rtl/xram_ctrl.sv
// xram_ctrl: arbitrates two word requesters onto an external byte-wide SRAM
// reached through a multiplexed address/data bus with two address latches.
module xram_ctrl
  import xram_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [14:0] a_addr,
  input  logic [15:0] a_wdata,
  input  logic [1:0]  a_be,
  output logic [15:0] a_rdata,
  output logic        a_ack,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [14:0] b_addr,
  input  logic [15:0] b_wdata,
  input  logic [1:0]  b_be,
  output logic [15:0] b_rdata,
  output logic        b_ack,
  output logic        xlal,
  output logic        xlah,
  output logic        xbh,
  output logic        xoeb,
  output logic        xweb,
  output logic [7:0]  uio_out,
  output logic [7:0]  uio_oe,
  input  logic [7:0]  uio_in
);

  xram_state_t state_r, state_nx_s, first_byte_s;
  xram_req_t   cap_r, win_s;
  xram_bus_t   bus_s, bus_r;
  logic [1:0]  pend_r, gnt_s;
  logic        port_s, arb_en_s, skip_lah_s, hi_byte_s;
  logic        hl_valid_r;
  logic [6:0]  hl_r;
  logic [7:0]  rlo_r;
  logic [15:0] a_rdata_r, b_rdata_r;
  logic        a_ack_r, b_ack_r, a_ack_s, b_ack_s;

  assign arb_en_s = (state_r == ST_IDLE) && (pend_r == 2'd0);

  xram_arb u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({b_req, a_req}),
    .en    (arb_en_s),
    .gnt   (gnt_s),
    .last  (port_s)
  );

  // Winner's request fields
  always_comb begin
    win_s = '0;
    if (gnt_s[1]) begin
      win_s = '{we: b_we, addr: b_addr, wdata: b_wdata, be: b_be};
    end else begin
      win_s = '{we: a_we, addr: a_addr, wdata: a_wdata, be: a_be};
    end
  end

  // Capture at the grant edge; pend_r counts idle dwell cycles before the
  // sequence starts (one more for an empty write so its ack comes one later)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_r  <= '0;
      pend_r <= 2'd0;
    end else if (gnt_s != 2'b00) begin
      cap_r  <= win_s;
      pend_r <= (win_s.we && (win_s.be == 2'b00)) ? 2'd2 : 2'd1;
    end else if (pend_r != 2'd0) begin
      pend_r <= pend_r - 2'd1;
    end
  end

  assign skip_lah_s   = hl_valid_r && (cap_r.addr[14:8] == hl_r);
  assign first_byte_s = (cap_r.we && !cap_r.be[0]) ? ST_B1S : ST_B0S;

  // Sequencer next state
  always_comb begin
    state_nx_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (pend_r == 2'd1) begin
          state_nx_s = (cap_r.we && (cap_r.be == 2'b00)) ? ST_ACK : ST_LAL;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LAL:  state_nx_s = skip_lah_s ? first_byte_s : ST_LAH;
      ST_LAH:  state_nx_s = first_byte_s;
      ST_B0S:  state_nx_s = ST_B0P;
      ST_B0P:  state_nx_s = (cap_r.we && !cap_r.be[1]) ? ST_ACK : ST_B1S;
      ST_B1S:  state_nx_s = ST_B1P;
      ST_B1P:  state_nx_s = ST_ACK;
      ST_ACK:  state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  assign hi_byte_s = (state_nx_s == ST_B1S) || (state_nx_s == ST_B1P);

  // Bus and ack values for the state being entered, so registers line up with it
  always_comb begin
    bus_s   = BUS_IDLE;
    a_ack_s = 1'b0;
    b_ack_s = 1'b0;
    case (state_nx_s)
      ST_LAL: begin
        bus_s.uio_oe  = 8'hFF;
        bus_s.uio_out = cap_r.addr[7:0];
        bus_s.xlal    = 1'b1;
      end
      ST_LAH: begin
        bus_s.uio_oe  = 8'hFF;
        bus_s.uio_out = {1'b0, cap_r.addr[14:8]};
        bus_s.xlah    = 1'b1;
      end
      ST_B0S, ST_B0P, ST_B1S, ST_B1P: begin
        bus_s.xbh = hi_byte_s;
        if (cap_r.we) begin
          bus_s.uio_oe  = 8'hFF;
          bus_s.uio_out = pick_byte(cap_r.wdata, hi_byte_s);
          bus_s.xweb    = !((state_nx_s == ST_B0P) || (state_nx_s == ST_B1P));
        end else begin
          bus_s.xoeb = 1'b0;
        end
      end
      ST_ACK: begin
        if (port_s == PORT_B) begin
          b_ack_s = 1'b1;
        end else begin
          a_ack_s = 1'b1;
        end
      end
      default: bus_s = BUS_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      bus_r   <= BUS_IDLE;
      a_ack_r <= 1'b0;
      b_ack_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      bus_r   <= bus_s;
      a_ack_r <= a_ack_s;
      b_ack_r <= b_ack_s;
    end
  end

  // Read bytes sampled at the end of each strobe phase; word lands with the ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rlo_r     <= 8'h00;
      a_rdata_r <= 16'h0000;
      b_rdata_r <= 16'h0000;
    end else if (!cap_r.we) begin
      if (state_r == ST_B0P) begin
        rlo_r <= uio_in;
      end else if (state_r == ST_B1P) begin
        if (port_s == PORT_B) begin
          b_rdata_r <= {uio_in, rlo_r};
        end else begin
          a_rdata_r <= {uio_in, rlo_r};
        end
      end
    end
  end

  // Remember what the external high latch holds
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hl_valid_r <= 1'b0;
      hl_r       <= 7'd0;
    end else if (state_r == ST_LAH) begin
      hl_valid_r <= 1'b1;
      hl_r       <= cap_r.addr[14:8];
    end
  end

  assign xlal    = bus_r.xlal;
  assign xlah    = bus_r.xlah;
  assign xbh     = bus_r.xbh;
  assign xoeb    = bus_r.xoeb;
  assign xweb    = bus_r.xweb;
  assign uio_out = bus_r.uio_out;
  assign uio_oe  = bus_r.uio_oe;
  assign a_ack   = a_ack_r;
  assign b_ack   = b_ack_r;
  assign a_rdata = a_rdata_r;
  assign b_rdata = b_rdata_r;

endmodule

// File: tb/tb_xram_ctrl.sv
// tb_xram_ctrl: directed and random accesses against a byte-wide SRAM model
// on the multiplexed bus, checked against a word-level reference memory.
module tb_xram_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [14:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic [1:0]  a_be, b_be;
  logic        a_ack, b_ack;
  logic        xlal, xlah, xbh, xoeb, xweb;
  logic [7:0]  uio_out, uio_oe, uio_in;

  int n_checks = 0;
  int n_err    = 0;

  // reference model state
  logic [15:0] ref_mem [0:32767];
  logic        m_hl_valid;
  logic [6:0]  m_hl;
  logic        m_last;

  // physical SRAM model and bus observations
  logic [7:0]  sram [0:65535];
  logic [7:0]  lat_lo, lat_hi, lal_val, lah_val;
  int          n_lah = 0, n_web = 0, n_lo_web = 0;

  xram_ctrl dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
    .a_rdata(a_rdata), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
    .b_rdata(b_rdata), .b_ack(b_ack),
    .xlal(xlal), .xlah(xlah), .xbh(xbh), .xoeb(xoeb), .xweb(xweb),
    .uio_out(uio_out), .uio_oe(uio_oe), .uio_in(uio_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SRAM behaviour and bus-protocol checks, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      chk("drive_conflict", {31'd0, (uio_oe == 8'hFF) && (xoeb == 1'b0)}, 32'd0);
      if (xweb == 1'b0) begin
        chk("xweb_without_drive", {24'd0, uio_oe}, 32'h0000_00FF);
        sram[{lat_hi[6:0], lat_lo, xbh}] = uio_out;
        n_web++;
        if (!xbh) n_lo_web++;
      end
      if (xlal) begin lat_lo = uio_out; lal_val = uio_out; end
      if (xlah) begin lat_hi = uio_out; lah_val = uio_out; n_lah++; end
      uio_in = (xoeb == 1'b0) ? sram[{lat_hi[6:0], lat_lo, xbh}] : 8'h00;
    end
  end

  task automatic drive_port(input logic port, input logic req, input logic we,
                            input logic [14:0] addr, input logic [15:0] wdata, input logic [1:0] be);
    if (port) begin
      b_req = req; b_we = we; b_addr = addr; b_wdata = wdata; b_be = be;
    end else begin
      a_req = req; a_we = we; a_addr = addr; a_wdata = wdata; a_be = be;
    end
  endtask

  task automatic check_idle(input string tag);
    chk(tag, {9'd0, xlal, xlah, xbh, xoeb, xweb, uio_oe, uio_out, a_ack, b_ack},
        {9'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0});
  endtask

  // One complete access; latency and latch use predicted from the access shape
  task automatic access(input logic port, input logic we, input logic [14:0] addr,
                        input logic [15:0] wdata, input logic [1:0] be, input string tag);
    logic nullw, lah_exp, got, stray;
    int   nb, exp_lat, lat, lah0, web0;
    nullw   = we && (be == 2'b00);
    lah_exp = !nullw && !(m_hl_valid && (m_hl == addr[14:8]));
    nb      = we ? (int'(be[0]) + int'(be[1])) : 2;
    exp_lat = nullw ? 2 : 2 + int'(lah_exp) + 2 * nb;
    @(negedge clk);
    drive_port(port, 1'b1, we, addr, wdata, be);
    lah0 = n_lah;
    web0 = n_web;
    @(posedge clk);
    lat = 0; got = 1'b0; stray = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if ((port ? a_ack : b_ack) == 1'b1) stray = 1'b1;
      if ((port ? b_ack : a_ack) == 1'b1) got = 1'b1;
      else if (lat == 1 && !nullw) drive_port(port, 1'b1, we, 15'($urandom), 16'($urandom), be);
    end
    chk({tag, "_ack_seen"}, {31'd0, got}, 32'd1);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_stray_ack"}, {31'd0, stray}, 32'd0);
    chk({tag, "_lah_count"}, n_lah - lah0, {31'd0, lah_exp});
    if (we) begin
      if (be[0]) ref_mem[addr][7:0]  = wdata[7:0];
      if (be[1]) ref_mem[addr][15:8] = wdata[15:8];
      chk({tag, "_sram_lo"}, {24'd0, sram[{addr, 1'b0}]}, {24'd0, ref_mem[addr][7:0]});
      chk({tag, "_sram_hi"}, {24'd0, sram[{addr, 1'b1}]}, {24'd0, ref_mem[addr][15:8]});
      if (nullw) chk({tag, "_no_strobe"}, n_web - web0, 32'd0);
    end else begin
      chk({tag, "_rdata"}, {16'd0, port ? b_rdata : a_rdata}, {16'd0, ref_mem[addr]});
    end
    @(negedge clk);
    drive_port(port, 1'b0, we, addr, wdata, be);
    @(posedge clk); #1;
    chk({tag, "_ack_width"}, {31'd0, a_ack | b_ack}, 32'd0);
    if (lah_exp) begin m_hl_valid = 1'b1; m_hl = addr[14:8]; end
    m_last = port;
  endtask

  initial begin
    logic        p, we, exp_port, prev, found;
    logic [1:0]  be;
    logic [14:0] addr;
    logic [14:0] rr_addr [2];
    logic [6:0]  hi_tab [3];
    int          lo0, n_acks, cyc;

    reset = 1'b1;
    drive_port(1'b0, 1'b0, 1'b0, 15'd0, 16'd0, 2'b00);
    drive_port(1'b1, 1'b0, 1'b0, 15'd0, 16'd0, 2'b00);
    uio_in = 8'h00; lat_lo = 8'h00; lat_hi = 8'h00; lal_val = 8'h00; lah_val = 8'h00;
    for (int w = 0; w < 32768; w++) begin
      ref_mem[w]     = 16'($urandom);
      sram[2 * w]     = ref_mem[w][7:0];
      sram[2 * w + 1] = ref_mem[w][15:8];
    end
    m_hl_valid = 1'b0; m_hl = 7'd0; m_last = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_idle");
    chk("reset_rdata", {a_rdata, b_rdata}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // full write then read-back of the same word
    access(1'b0, 1'b1, 15'h1234, 16'hBEEF, 2'b11, "wr1234");
    chk("lal_bus", {24'd0, lal_val}, 32'h34);
    chk("lah_bus", {24'd0, lah_val}, 32'h12);
    chk("sram_2468", {24'd0, sram[16'h2468]}, 32'hEF);
    chk("sram_2469", {24'd0, sram[16'h2469]}, 32'hBE);
    access(1'b0, 1'b0, 15'h1234, 16'h0000, 2'b00, "rd1234");
    chk("rd1234_value", {16'd0, a_rdata}, 32'hBEEF);

    // high-byte-only write and an empty write from B
    lo0 = n_lo_web;
    access(1'b1, 1'b1, 15'h0100, 16'h55AA, 2'b10, "wr_be10");
    chk("sram_0201", {24'd0, sram[16'h0201]}, 32'h55);
    chk("be10_no_low_strobe", n_lo_web - lo0, 32'd0);
    access(1'b1, 1'b1, 15'h0101, 16'h1111, 2'b00, "wr_be00");

    // simultaneous held requests alternate
    rr_addr[0] = 15'h0123; rr_addr[1] = 15'h4567;
    @(negedge clk);
    drive_port(1'b0, 1'b1, 1'b0, rr_addr[0], 16'd0, 2'b11);
    drive_port(1'b1, 1'b1, 1'b0, rr_addr[1], 16'd0, 2'b11);
    exp_port = ~m_last;
    n_acks = 0; prev = 1'b0; cyc = 0;
    while (n_acks < 3 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (a_ack || b_ack) begin
        chk("rr_one_port", {31'd0, a_ack & b_ack}, 32'd0);
        chk("rr_pulse_width", {31'd0, prev}, 32'd0);
        chk("rr_order", {31'd0, b_ack}, {31'd0, exp_port});
        chk("rr_rdata", {16'd0, b_ack ? b_rdata : a_rdata}, {16'd0, ref_mem[rr_addr[b_ack]]});
        m_last = b_ack; m_hl_valid = 1'b1; m_hl = rr_addr[b_ack][14:8];
        exp_port = ~exp_port;
        n_acks++;
        if (n_acks == 3) begin
          @(negedge clk);
          a_req = 1'b0; b_req = 1'b0;
        end
      end
      prev = a_ack | b_ack;
    end
    chk("rr_three_acks", n_acks, 32'd3);
    @(posedge clk); #1;
    chk("rr_ack_drop", {31'd0, a_ack | b_ack}, 32'd0);

    // random traffic over a few high bytes so latch reuse happens
    hi_tab[0] = 7'h12; hi_tab[1] = 7'h02; hi_tab[2] = 7'h7F;
    for (int i = 0; i < 40; i++) begin
      p    = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      be   = 2'($urandom_range(0, 3));
      addr = {hi_tab[$urandom_range(0, 2)], 8'($urandom)};
      access(p, we, addr, 16'($urandom), be, "rand");
    end

    // reset in the middle of a write, at the low-byte strobe
    addr = {m_hl, 8'h40};
    @(negedge clk);
    drive_port(1'b0, 1'b1, 1'b1, addr, 16'hC0DE, 2'b11);
    found = 1'b0; cyc = 0;
    while (!found && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (xweb == 1'b0 && xbh == 1'b0) found = 1'b1;
    end
    chk("rst_b0p_reached", {31'd0, found}, 32'd1);
    reset = 1'b1;
    #1;
    check_idle("rst_async_idle");
    @(negedge clk);
    a_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("rst_held_no_ack");
    chk("rst_rdata", {a_rdata, b_rdata}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_hl_valid = 1'b0; m_last = 1'b1;
    ref_mem[addr] = {sram[{addr, 1'b1}], sram[{addr, 1'b0}]};
    access(1'b0, 1'b0, addr, 16'h0000, 2'b00, "post_rst_rd");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
